ads868x_scan_ctrl: RTL and testbench
====================================

Name: ads868x_scan_ctrl

Overview:
Scan sequencer for the ADS868x front end. It steps the 32-input analog mux (4 bank enables × 8 CH_SEL codes) through a latched channel mask, with break-before-make and settling per channel. For each enabled channel it triggers one ADS868x conversion over SPI and reads back the 16-bit result. Results go out on a simple write port to the sample buffer, and a done pulse marks the end of a scan; FPGA_DAT_FIN and the MCU interrupt are derived from that pulse downstream.

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period (≥1)
BBM_CYCLES, 4, cycles with all bank enables low before a new channel is enabled (≥1)
SETTLE_CYCLES, 200, cycles after enable before conversion start (≥1)
CONV_CYCLES, 100, cycles CS_N is held high for conversion (≥1)
RST_CYCLES, 64, cycles ad_rst_n is held low after rst (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin scan
abort  in  1  one-cycle pulse; stop scan
cfg_ch_mask  in  32  bit i enables channel i; latched on accepted start
ptp_trg  in  1  asynchronous PTP trigger (used only with the optional feature)
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan completion
wr_en  out  1  result valid
wr_addr  out  5  channel index of the result
wr_data  out  16  conversion result
ch_sel  out  3  mux code, equal to channel index [2:0]
en_tch_a, en_pch_a, en_tch_b, en_pch_b  out  1 each  bank enables, selected by channel index [4:3] = 0,1,2,3
ad_rst_n  out  1  ADC reset, active low
spi_sclk, spi_cs_n, spi_mosi  out  1 each  ADC SPI, mode 0
spi_miso  in  1  ADC SDO

Behaviour:
- Clock and reset: a single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, ch_sel=0, all enables=0, ad_rst_n=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0.
- ad_rst_n is released to 1 RST_CYCLES cycles after rst deasserts. Starts before release are ignored.
- FSM states: ADC_RST → IDLE → BBM → SETTLE → CONV → XFER → STORE → (BBM | DONE) → IDLE.
- IDLE, start accepted:
  - Latch the mask.
  - If mask==0: done=1 on the next cycle, busy stays 0, no writes.
  - Otherwise: busy=1 on the next cycle; go to BBM with the lowest set index.
- start while busy: ignored.
- BBM: all enables=0 and ch_sel updated, held BBM_CYCLES cycles.
- SETTLE: the selected enable=1, held SETTLE_CYCLES cycles. Exactly one enable is ever high.
- CONV: spi_cs_n=1 for CONV_CYCLES cycles. The CS rising edge from the previous low starts the conversion; on the first channel, CS is driven low for one SCLK half-period first.
- XFER:
  - spi_cs_n=0, 32 SCLK periods, MSB first.
  - MISO is sampled on the SCLK rising edge; MOSI=0 (NOP).
  - The first 16 received bits form the result.
  - spi_cs_n returns to 1 one half-period after the last falling edge.
- STORE: wr_en=1 for exactly one cycle with wr_addr=index and wr_data=result. Then go to the next higher set index (via BBM), or to DONE if none remain.
- DONE: done=1 for one cycle, busy=0, enables all 0, ch_sel held; return to IDLE.
- abort, any state except ADC_RST: next cycle in IDLE with spi_cs_n=1, spi_sclk=0, enables=0, busy=0. No done pulse; a pending STORE is dropped.
- Simultaneous start and abort in IDLE: abort wins, start is ignored.
- rst mid-scan: all outputs take their reset values on the next cycle and the ADC reset sequence reruns.

Optional Feature:
- Macro: ADS868X_SCAN_PTP_TRIG_EN.
- Defined: ptp_trg passes a 2-flop synchronizer plus a rising-edge detector, and each detected edge acts as a start pulse with the same rules. A start and an edge in the same cycle count as one start.
- Undefined: ptp_trg is unused and no synchronizer is instantiated.

Decomposition:
- Package ads868x_pkg:
  - FSM state enum;
  - bank index constants BANK_TCH_A=0, BANK_PCH_A=1, BANK_TCH_B=2, BANK_PCH_B=3;
  - FRAME_BITS=32, RESULT_BITS=16, NUM_CH=32.
- Sub-module ads868x_spi_xfer: SCLK divider and 32-bit shifter.
  - Inputs: go.
  - Outputs: sclk, cs_n, mosi, rdata[15:0], a one-cycle xfer_done.
- The controller owns mux timing, mask walking and CONV timing.

Test Plan:
- Bench parameters for all scenarios: CLK_DIV=2, BBM=4, SETTLE=20, CONV=10, RST=8.
- rst pulse → ad_rst_n low exactly 8 cycles after rst drops; a start during that window → no busy.
- mask=0x0000_0005, ADC model returns 0xA5A5 and 0x1234 → wr_en twice, wr_addr 0 then 2, wr_data 0xA5A5 then 0x1234. en_tch_a high during both; ch_sel 0 then 2. One done pulse; 32 SCLK rising edges per frame.
- mask=0x8000_0100 → channel 8 asserts en_pch_a, channel 31 asserts en_pch_b with ch_sel=7. Enables are all low for ≥4 cycles between them and never two high at once.
- abort mid-XFER of the first channel of mask=0xFFFF_FFFF → next cycle busy=0, spi_cs_n=1, enables 0, no wr_en, no done. A new start then scans from channel 0.
- mask=0 start → done one cycle later, busy never high. start during busy → wr count unchanged (32 for full mask).
- With ADS868X_SCAN_PTP_TRIG_EN: ptp_trg rising edge → busy asserts within 4 cycles. ptp_trg held high → only one scan.

Source files
------------

// File: rtl/ads868x_pkg.sv
// Shared definitions for the ADS868x scan sequencer: FSM encoding, bank
// mapping of the analog mux and SPI frame geometry.
package ads868x_pkg;

  typedef enum logic [2:0] {
    ST_ADC_RST,
    ST_IDLE,
    ST_BBM,
    ST_SETTLE,
    ST_CONV,
    ST_XFER,
    ST_STORE,
    ST_DONE
  } scan_state_e;

  localparam logic [1:0] BANK_TCH_A = 2'd0;
  localparam logic [1:0] BANK_PCH_A = 2'd1;
  localparam logic [1:0] BANK_TCH_B = 2'd2;
  localparam logic [1:0] BANK_PCH_B = 2'd3;

  localparam int FRAME_BITS  = 32;
  localparam int RESULT_BITS = 16;
  localparam int NUM_CH      = 32;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ads868x_scan_ctrl_if.sv
// Control and sample-buffer write port of the scan sequencer. The master
// issues start/abort with a mask; the slave reports busy/done and writes.
interface ads868x_scan_ctrl_if;
  logic        start;
  logic        abort;
  logic [31:0] cfg_ch_mask;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  modport master (
    output start, abort, cfg_ch_mask,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, abort, cfg_ch_mask,
    output busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ads868x_spi_xfer.sv
// One 32-bit SPI mode-0 frame to the ADS868x: CS low, 32 SCLK periods,
// MISO captured on rising edges, MOSI held at NOP. Pulses xfer_done at the end.
module ads868x_spi_xfer
  import ads868x_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   go,
  input  logic                   miso,
  output logic                   sclk,
  output logic                   cs_n,
  output logic                   mosi,
  output logic [RESULT_BITS-1:0] rdata,
  output logic                   xfer_done
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [6:0]  HALF_LAST = 7'(2 * FRAME_BITS);

  logic                  r_active;
  logic [15:0]           r_div;
  logic [6:0]            r_half;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_done;
  logic [FRAME_BITS-1:0] r_shift;

  // r_half counts SCLK half-periods; the extra one after the last falling
  // edge keeps CS low for a half-period before it returns high.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_half   <= '0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_done   <= 1'b0;
      r_shift  <= '0;
    end else begin
      r_done <= 1'b0;
      if (go && !r_active) begin
        r_active <= 1'b1;
        r_cs_n   <= 1'b0;
        r_sclk   <= 1'b0;
        r_div    <= '0;
        r_half   <= '0;
      end else if (r_active) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          if (r_half == HALF_LAST) begin
            r_active <= 1'b0;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_half <= r_half + 7'd1;
            r_sclk <= ~r_sclk;
            if (!r_sclk) r_shift <= {r_shift[FRAME_BITS-2:0], miso};
          end
        end else begin
          r_div <= r_div + 16'd1;
        end
      end
    end
  end

  assign sclk      = r_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = 1'b0;
  assign rdata     = r_shift[FRAME_BITS-1:FRAME_BITS-RESULT_BITS];
  assign xfer_done = r_done;

endmodule

// File: rtl/ads868x_scan_ctrl.sv
// ADS868x scan sequencer: walks the channel mask through the 4x8 analog mux
// with break-before-make and settling, converts and stores each channel.
// Optional macro ADS868X_SCAN_PTP_TRIG_EN lets a ptp_trg rising edge act as start.
module ads868x_scan_ctrl
  import ads868x_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int BBM_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 200,
  parameter int CONV_CYCLES   = 100,
  parameter int RST_CYCLES    = 64
) (
  input  logic                clk,
  input  logic                rst,
  ads868x_scan_ctrl_if.slave  bus,
  input  logic                ptp_trg,
  output logic [2:0]          ch_sel,
  output logic                en_tch_a,
  output logic                en_pch_a,
  output logic                en_tch_b,
  output logic                en_pch_b,
  output logic                ad_rst_n,
  output logic                spi_sclk,
  output logic                spi_cs_n,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  localparam int CW = 16;
  localparam logic [CW-1:0] RST_LAST        = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] BBM_LAST        = CW'(BBM_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST     = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST       = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST_FIRST = CW'(CONV_CYCLES + CLK_DIV - 1);
  localparam logic [CW-1:0] PRE_CS_CYCLES   = CW'(CLK_DIV);

  scan_state_e            r_state;
  logic [CW-1:0]          r_cnt;
  logic [4:0]             r_ch_idx;
  logic [NUM_CH-1:0]      r_mask_rem;
  logic                   r_first;
  logic [RESULT_BITS-1:0] r_result;

  scan_state_e            w_state_d;
  logic [CW-1:0]          w_cnt_d;
  logic [4:0]             w_idx_d;
  logic [NUM_CH-1:0]      w_rem_d;
  logic                   w_first_d;
  logic [RESULT_BITS-1:0] w_result_d;
  logic                   w_go;

  logic                   w_start;
  logic [NUM_CH-1:0]      w_pick_src;
  logic [4:0]             w_pick;
  logic [NUM_CH-1:0]      w_rest;
  logic                   w_clr;
  logic                   w_xfer_sclk;
  logic                   w_xfer_cs_n;
  logic                   w_xfer_mosi;
  logic [RESULT_BITS-1:0] w_xfer_rdata;
  logic                   w_xfer_done;
  logic                   w_conv_cs_n;
  logic                   w_en_on;
  logic [1:0]             w_bank;

`ifdef ADS868X_SCAN_PTP_TRIG_EN
  logic r_ptp_meta;
  logic r_ptp_sync;
  logic r_ptp_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptp_meta <= 1'b0;
      r_ptp_sync <= 1'b0;
      r_ptp_prev <= 1'b0;
    end else begin
      r_ptp_meta <= ptp_trg;
      r_ptp_sync <= r_ptp_meta;
      r_ptp_prev <= r_ptp_sync;
    end
  end

  assign w_start = bus.start | (r_ptp_sync & ~r_ptp_prev);
`else
  logic w_unused_ptp;
  assign w_unused_ptp = ptp_trg;
  assign w_start      = bus.start;
`endif

  // The first channel comes from the incoming mask, later ones from the remainder.
  assign w_pick_src = (r_state == ST_IDLE) ? bus.cfg_ch_mask : r_mask_rem;
  assign w_pick     = lowest_set(w_pick_src);
  assign w_rest     = w_pick_src & ~(NUM_CH'(1) << w_pick);
  assign w_clr      = bus.abort && (r_state != ST_ADC_RST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ADC_RST;
      r_cnt      <= '0;
      r_ch_idx   <= '0;
      r_mask_rem <= '0;
      r_first    <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_ch_idx   <= w_idx_d;
      r_mask_rem <= w_rem_d;
      r_first    <= w_first_d;
      r_result   <= w_result_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt + 16'd1;
    w_idx_d    = r_ch_idx;
    w_rem_d    = r_mask_rem;
    w_first_d  = r_first;
    w_result_d = r_result;
    w_go       = 1'b0;
    case (r_state)
      ST_ADC_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_d = ST_IDLE;
          w_cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        w_cnt_d = '0;
        if (w_start && !bus.abort) begin
          if (bus.cfg_ch_mask == '0) begin
            w_state_d = ST_DONE;
          end else begin
            w_idx_d   = w_pick;
            w_rem_d   = w_rest;
            w_first_d = 1'b1;
            w_state_d = ST_BBM;
          end
        end
      end
      ST_BBM: begin
        if (r_cnt == BBM_LAST) begin
          w_state_d = ST_SETTLE;
          w_cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_d = ST_CONV;
          w_cnt_d   = '0;
        end
      end
      ST_CONV: begin
        if (r_cnt == (r_first ? CONV_LAST_FIRST : CONV_LAST)) begin
          w_state_d = ST_XFER;
          w_cnt_d   = '0;
          w_go      = 1'b1;
        end
      end
      ST_XFER: begin
        w_cnt_d = r_cnt;
        if (w_xfer_done) begin
          w_result_d = w_xfer_rdata;
          w_state_d  = ST_STORE;
        end
      end
      ST_STORE: begin
        w_cnt_d   = '0;
        w_first_d = 1'b0;
        if (r_mask_rem != '0) begin
          w_idx_d   = w_pick;
          w_rem_d   = w_rest;
          w_state_d = ST_BBM;
        end else begin
          w_state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        w_cnt_d   = '0;
        w_state_d = ST_IDLE;
      end
      default: begin
        w_cnt_d   = '0;
        w_state_d = ST_ADC_RST;
      end
    endcase
    if (w_clr) begin
      w_state_d = ST_IDLE;
      w_cnt_d   = '0;
      w_go      = 1'b0;
    end
  end

  ads868x_spi_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .go        (w_go),
    .miso      (spi_miso),
    .sclk      (w_xfer_sclk),
    .cs_n      (w_xfer_cs_n),
    .mosi      (w_xfer_mosi),
    .rdata     (w_xfer_rdata),
    .xfer_done (w_xfer_done)
  );

  // First channel has no earlier frame, so CS dips low to create the convert edge.
  assign w_conv_cs_n = !((r_state == ST_CONV) && r_first && (r_cnt < PRE_CS_CYCLES));
  assign w_en_on     = (r_state == ST_SETTLE) || (r_state == ST_CONV) ||
                       (r_state == ST_XFER)   || (r_state == ST_STORE);
  assign w_bank      = r_ch_idx[4:3];

  assign en_tch_a = w_en_on && (w_bank == BANK_TCH_A);
  assign en_pch_a = w_en_on && (w_bank == BANK_PCH_A);
  assign en_tch_b = w_en_on && (w_bank == BANK_TCH_B);
  assign en_pch_b = w_en_on && (w_bank == BANK_PCH_B);
  assign ch_sel   = r_ch_idx[2:0];
  assign ad_rst_n = (r_state != ST_ADC_RST);
  assign spi_sclk = w_xfer_sclk;
  assign spi_cs_n = w_xfer_cs_n & w_conv_cs_n;
  assign spi_mosi = w_xfer_mosi;

  assign bus.busy    = (r_state == ST_BBM)  || (r_state == ST_SETTLE) ||
                       (r_state == ST_CONV) || (r_state == ST_XFER)   ||
                       (r_state == ST_STORE);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.wr_en   = (r_state == ST_STORE);
  assign bus.wr_addr = r_ch_idx;
  assign bus.wr_data = r_result;

endmodule

// File: tb/tb_ads868x_scan_ctrl.sv
// Bench for ads868x_scan_ctrl: ADC/mux model, scoreboard of expected writes,
// randomized masks and conversion data, abort/reset/boundary scenarios.
module tb_ads868x_scan_ctrl;

  localparam int CLK_DIV = 2;
  localparam int BBM     = 4;
  localparam int SETTLE  = 20;
  localparam int CONV    = 10;
  localparam int RSTC    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ptp_trg = 1'b0;
  logic       spi_miso = 1'b0;
  logic [2:0] ch_sel;
  logic       en_tch_a, en_pch_a, en_tch_b, en_pch_b;
  logic       ad_rst_n, spi_sclk, spi_cs_n, spi_mosi;

  ads868x_scan_ctrl_if bus();

  ads868x_scan_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .BBM_CYCLES    (BBM),
    .SETTLE_CYCLES (SETTLE),
    .CONV_CYCLES   (CONV),
    .RST_CYCLES    (RSTC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ptp_trg  (ptp_trg),
    .ch_sel   (ch_sel),
    .en_tch_a (en_tch_a),
    .en_pch_a (en_pch_a),
    .en_tch_b (en_tch_b),
    .en_pch_b (en_pch_b),
    .ad_rst_n (ad_rst_n),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [20:0] exp_q[$];          // {addr, data}
  logic [15:0] adc_tab[32];       // analog value presented by each mux input
  int          wr_cnt    = 0;
  int          done_cnt  = 0;
  bit          busy_seen = 1'b0;
  bit          skip_frame = 1'b0;
  int          rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ADC + mux model and monitor ----------------
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_any_en = 1'b0;
  int          low_run = 0;
  bit          seen_en = 1'b0;
  logic [31:0] adc_sh = '0;

  always @(negedge clk) begin
    logic [3:0]  en;
    logic [1:0]  bank;
    logic [20:0] got;
    logic [20:0] exp_v;
    en   = {en_pch_b, en_tch_b, en_pch_a, en_tch_a};
    bank = en[1] ? 2'd1 : en[2] ? 2'd2 : en[3] ? 2'd3 : 2'd0;
    if (rst) begin
      rises   = 0;
      seen_en = 1'b0;
      low_run = 0;
    end else begin
      // The ADC sees whichever mux input is connected when a frame opens.
      if (prev_cs && !spi_cs_n) begin
        adc_sh   = {adc_tab[{bank, ch_sel}], 16'h0000};
        spi_miso = adc_sh[31];
        rises    = 0;
      end else if (!spi_cs_n && prev_sclk && !spi_sclk) begin
        adc_sh   = adc_sh << 1;
        spi_miso = adc_sh[31];
      end
      if (!spi_cs_n && !prev_sclk && spi_sclk) rises++;
      if (!prev_cs && spi_cs_n && rises != 0) begin
        if (!skip_frame) check("sclk_rises_per_frame", rises, 32);
        rises = 0;
      end

      check("enables_one_hot", ($countones(en) <= 1), 1);
      if (en != 4'b0) begin
        if (!prev_any_en && seen_en) check("bbm_gap_ge_4", (low_run >= BBM), 1);
        seen_en = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_any_en = (en != 4'b0);

      if (bus.wr_en) begin
        wr_cnt++;
        got = {bus.wr_addr, bus.wr_data};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: addr %0d data 0x%h, no write expected",
                   bus.wr_addr, bus.wr_data);
        end else begin
          exp_v = exp_q.pop_front();
          check("wr_addr_data", got, exp_v);
          check("wr_bank_enable", en, 4'b0001 << exp_v[20:19]);
          check("wr_ch_sel", ch_sel, exp_v[18:16]);
        end
      end
      if (bus.done) done_cnt++;
      if (bus.busy) busy_seen = 1'b1;
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [31:0] mask);
    @(posedge clk); #1;
    bus.cfg_ch_mask = mask;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start       = 1'b0;
  endtask

  task automatic fill_tab();
    for (int i = 0; i < 32; i++) adc_tab[i] = 16'($urandom);
  endtask

  task automatic push_exp(input logic [31:0] mask);
    for (int i = 0; i < 32; i++)
      if (mask[i]) exp_q.push_back({5'(i), adc_tab[i]});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < budget);
    check(name, bus.done, 1);
  endtask

  task automatic run_scan(input string name, input logic [31:0] mask);
    int d0, w0;
    push_exp(mask);
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start(mask);
    wait_done(name, 8000);
    @(negedge clk);
    check("scan_done_pulses", done_cnt - d0, 1);
    check("scan_write_count", wr_cnt - w0, $countones(mask));
    check("scan_queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lowcnt, n, d0, w0;
    logic [31:0] m;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.cfg_ch_mask = '0;
    fill_tab();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_enables", {en_pch_b, en_tch_b, en_pch_a, en_tch_a}, 0);
    check("rst_ad_rst_n", ad_rst_n, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);

    // ADC reset window; a start inside it must be ignored
    @(posedge clk); #1;
    rst = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ad_rst_n) break;
      lowcnt++;
      if (i == 2) begin
        bus.cfg_ch_mask = 32'h5;
        bus.start       = 1'b1;
      end
      if (i == 3) bus.start = 1'b0;
    end
    check("ad_rst_low_cycles", lowcnt, RSTC);
    repeat (5) @(negedge clk);
    check("start_in_rst_window_no_busy", busy_seen, 0);

    // Two-channel scan on bank TCH_A with fixed ADC data
    fill_tab();
    adc_tab[0] = 16'hA5A5;
    adc_tab[2] = 16'h1234;
    run_scan("mask5_done", 32'h0000_0005);

    // Bank boundaries: channel 8 (PCH_A) and channel 31 (PCH_B)
    fill_tab();
    run_scan("mask_8_31_done", 32'h8000_0100);

    // Random sparse masks with random ADC data
    for (int k = 0; k < 3; k++) begin
      fill_tab();
      m = $urandom & $urandom & $urandom;
      m[$urandom_range(0, 31)] = 1'b1;
      run_scan("random_mask_done", m);
    end

    // Empty mask: done on the next cycle, never busy
    busy_seen = 1'b0;
    pulse_start(32'h0);
    @(negedge clk);
    check("mask0_done_next_cycle", bus.done, 1);
    check("mask0_busy_low", bus.busy, 0);
    @(negedge clk);
    check("mask0_done_one_cycle", bus.done, 0);
    check("mask0_busy_never", busy_seen, 0);

    // start and abort together in IDLE: abort wins
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.cfg_ch_mask = 32'h5;
    bus.start       = 1'b1;
    bus.abort       = 1'b1;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    repeat (10) @(negedge clk);
    check("start_abort_no_busy", busy_seen, 0);
    check("start_abort_no_done", done_cnt - d0, 0);

    // Abort in the middle of the first frame of a full scan
    fill_tab();
    pulse_start(32'hFFFF_FFFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rises >= 8 && !spi_cs_n) && n < 2000);
    check("abort_reached_xfer", (n < 2000), 1);
    d0 = done_cnt;
    w0 = wr_cnt;
    skip_frame = 1'b1;
    bus.abort  = 1'b1;
    @(posedge clk); #1;
    bus.abort  = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_enables", {en_pch_b, en_tch_b, en_pch_a, en_tch_a}, 0);
    repeat (300) @(negedge clk);
    skip_frame = 1'b0;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_write", wr_cnt - w0, 0);

    // Full scan from channel 0; a second start while busy is ignored
    fill_tab();
    push_exp(32'hFFFF_FFFF);
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start(32'hFFFF_FFFF);
    repeat (500) @(negedge clk);
    pulse_start(32'h0000_0001);
    wait_done("full_scan_done", 8000);
    @(negedge clk);
    check("full_scan_writes", wr_cnt - w0, 32);
    check("full_scan_one_done", done_cnt - d0, 1);
    check("full_scan_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a scan
    fill_tab();
    pulse_start(32'h0000_0003);
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cs_n", spi_cs_n, 1);
    check("midrst_ad_rst_n", ad_rst_n, 0);
    check("midrst_enables", {en_pch_b, en_tch_b, en_pch_a, en_tch_a}, 0);
    check("midrst_ch_sel", ch_sel, 0);
    repeat (RSTC + 2) @(negedge clk);
    check("midrst_ad_rst_released", ad_rst_n, 1);
    fill_tab();
    run_scan("after_rst_scan_done", 32'h0000_0010);

`ifdef ADS868X_SCAN_PTP_TRIG_EN
    // PTP trigger: edge starts a scan, a held level does not restart it
    fill_tab();
    push_exp(32'h0000_0002);
    bus.cfg_ch_mask = 32'h0000_0002;
    d0 = done_cnt;
    @(posedge clk); #1;
    ptp_trg = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.busy && n < 10);
    check("ptp_busy_within_4", (n <= 4), 1);
    wait_done("ptp_scan_done", 2000);
    repeat (300) @(negedge clk);
    check("ptp_held_one_scan", done_cnt - d0, 1);
    ptp_trg = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
